rand_digit_server: RTL and testbench

Round-robin controller that shares one 16-bit Fibonacci LFSR among `NUM_REQ` game-logic requesters and hands each granted requester a single decimal digit (0–9) per transaction. It sits between the game FSMs and the random source, owns LFSR stepping and seeding, and removes modulo bias by rejection sampling with a bounded retry count.

---
 rtl/rand_ctrl_pkg.sv | 24 ++
 rtl/rand_digit_server_if.sv | 22 ++
 rtl/lfsr16_step.sv | 36 +++
 rtl/rand_digit_server.sv | 175 +++++++++++++++++
 tb/tb_rand_digit_server.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rand_ctrl_pkg.sv
// Shared types and constants for the random digit server: FSM states, LFSR taps/seed and digit base.
package rand_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAW    = 2'd1,
    ST_DELIVER = 2'd2
  } rand_state_e;

  localparam logic [15:0] LFSR_RESET_SEED = 16'hBEEF;

  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [3:0] DIGIT_BASE = 4'd10;

  // Fibonacci step: shift left, XOR of the taps enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    return {r[14:0], r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D]};
  endfunction

endpackage

// File: rtl/rand_digit_server_if.sv
// Request/grant/digit bundle between the game FSMs (master) and the digit server (slave).
interface rand_digit_server_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic               seed_load;
  logic [15:0]        seed;
  logic [NUM_REQ-1:0] gnt;
  logic               digit_valid;
  logic [3:0]         digit;
  logic               busy;

  modport master (
    output req, seed_load, seed,
    input  gnt, digit_valid, digit, busy
  );

  modport slave (
    input  req, seed_load, seed,
    output gnt, digit_valid, digit, busy
  );
endinterface

// File: rtl/lfsr16_step.sv
// 16-bit Fibonacci LFSR with explicit step and load enables; a zero load value is replaced by the reset seed.
module lfsr16_step
  import rand_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        step_en,
  input  logic        load_en,
  input  logic [15:0] load_val,
  output logic [3:0]  cand
);

  logic [15:0] lfsr_d;
  logic [15:0] lfsr_q;

  // An all-zero state would lock the register, so a zero seed falls back to the reset seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_en) begin
      lfsr_d = (load_val == 16'h0000) ? LFSR_RESET_SEED : load_val;
    end else if (step_en) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lfsr_q <= LFSR_RESET_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign cand = lfsr_q[3:0];

endmodule

// File: rtl/rand_digit_server.sv
// Round-robin server sharing one LFSR among NUM_REQ requesters, one decimal digit per grant.
// Macro RAND_REJECT_EN: rejection sampling with MAX_TRIES retries; otherwise a single mod-10 draw.
module rand_digit_server
  import rand_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_TRIES = 8
) (
  input logic                CLK,
  input logic                RESET,
  rand_digit_server_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_cfg
    $error("rand_digit_server: NUM_REQ or MAX_TRIES out of range");
  end

  rand_state_e        state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               digit_valid_q, digit_valid_d;
  logic [3:0]         digit_q, digit_d;
  logic               busy_q, busy_d;
`ifdef RAND_REJECT_EN
  localparam logic [3:0] TRIES_MAX = 4'(MAX_TRIES);
  logic [3:0]         tries_q, tries_d;
`endif

  logic [3:0]         cand;
  logic               step_en;
  logic               load_en;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   idx;
  logic               any_req;

  function automatic logic [3:0] digit_fold(input logic [3:0] c);
    return (c >= DIGIT_BASE) ? c - DIGIT_BASE : c;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] w);
    return (int'(w) == NUM_REQ - 1) ? '0 : w + 1'b1;
  endfunction

  lfsr16_step u_lfsr (
    .CLK      (CLK),
    .RESET    (RESET),
    .step_en  (step_en),
    .load_en  (load_en),
    .load_val (bus.seed),
    .cand     (cand)
  );

  // Scan downward so the set bit closest to ptr (cyclically) is the last assignment and wins.
  always_comb begin
    pick    = ptr_q;
    idx     = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (bus.req[idx]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    gnt_d         = gnt_q;
    digit_valid_d = 1'b0;
    digit_d       = digit_q;
    busy_d        = busy_q;
`ifdef RAND_REJECT_EN
    tries_d       = tries_q;
`endif
    step_en       = 1'b0;
    load_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.seed_load) begin
          load_en = 1'b1;
        end else if (any_req) begin
          state_d     = ST_DRAW;
          win_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          busy_d      = 1'b1;
`ifdef RAND_REJECT_EN
          tries_d     = 4'd0;
`endif
        end
      end

      ST_DRAW: begin
        step_en = 1'b1;
        // A vanished winner abandons the draw; the LFSR keeps the steps already taken.
        if (!bus.req[win_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = next_idx(win_q);
`ifdef RAND_REJECT_EN
        end else if (cand < DIGIT_BASE) begin
          state_d       = ST_DELIVER;
          digit_d       = cand;
          digit_valid_d = 1'b1;
        end else if (tries_q == TRIES_MAX) begin
          state_d       = ST_DELIVER;
          digit_d       = digit_fold(cand);
          digit_valid_d = 1'b1;
        end else begin
          tries_d = tries_q + 4'd1;
        end
`else
        end else begin
          state_d       = ST_DELIVER;
          digit_d       = digit_fold(cand);
          digit_valid_d = 1'b1;
        end
`endif
      end

      ST_DELIVER: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = next_idx(win_q);
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      gnt_q         <= '0;
      digit_valid_q <= 1'b0;
      digit_q       <= 4'd0;
      busy_q        <= 1'b0;
`ifdef RAND_REJECT_EN
      tries_q       <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      gnt_q         <= gnt_d;
      digit_valid_q <= digit_valid_d;
      digit_q       <= digit_d;
      busy_q        <= busy_d;
`ifdef RAND_REJECT_EN
      tries_q       <= tries_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.digit_valid = digit_valid_q;
  assign bus.digit       = digit_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_rand_digit_server.sv
// Bench for rand_digit_server: directed scenarios plus random transactions against a transaction-level model.
module tb_rand_digit_server;

  localparam int N    = 4;
  localparam int MT_A = 8;
  localparam int MT_B = 2;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  rand_digit_server_if #(.NUM_REQ(N)) ifa ();
  rand_digit_server_if #(.NUM_REQ(N)) ifb ();

  rand_digit_server #(.NUM_REQ(N), .MAX_TRIES(MT_A)) dut_a (.CLK(CLK), .RESET(RESET), .bus(ifa));
  rand_digit_server #(.NUM_REQ(N), .MAX_TRIES(MT_B)) dut_b (.CLK(CLK), .RESET(RESET), .bus(ifb));

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_lfsr;
  int          m_ptr;
  int          obs_gnt, obs_lat, obs_digit;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  function automatic int ref_pick(input logic [N-1:0] rv, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (rv[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // One whole draw: resulting LFSR, delivered digit and number of DRAW cycles consumed.
  task automatic ref_draw(input int mt, input logic [15:0] l_in, output logic [15:0] l_out,
                          output int digit, output int cycles);
    logic [15:0] l;
    int cand;
    int tries;
    l = l_in; tries = 0; digit = 0; cycles = 0;
`ifdef RAND_REJECT_EN
    for (int k = 0; k < 20; k++) begin
      cand = int'(l[3:0]);
      l = ref_step(l);
      cycles++;
      if (cand < 10) begin digit = cand; break; end
      if (tries == mt) begin digit = cand - 10; break; end
      tries++;
    end
`else
    cand = int'(l[3:0]);
    l = ref_step(l);
    cycles = 1;
    digit = cand % 10;
`endif
    l_out = l;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    ifa.req = '0; ifa.seed_load = 1'b0;
    ifb.req = '0; ifb.seed_load = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    m_lfsr = 16'hBEEF;
    m_ptr  = 0;
  endtask

  task automatic do_seed(input logic [15:0] val);
    @(negedge CLK);
    ifa.seed_load = 1'b1;
    ifa.seed      = val;
    ifa.req       = N'($urandom_range(1, (1 << N) - 1));
    @(posedge CLK); #1;
    chk("seed_no_grant", ifa.gnt, 0);
    chk("seed_not_busy", ifa.busy, 0);
    @(negedge CLK);
    ifa.seed_load = 1'b0;
    ifa.req       = '0;
    m_lfsr = (val == 16'h0000) ? 16'hBEEF : val;
  endtask

  task automatic do_txn(input logic [N-1:0] rv, input int abort_at, input bit busy_seed);
    int w, d, n;
    logic [15:0] l_after, l_ab;
    @(negedge CLK);
    ifa.req = rv;
    @(posedge CLK); #1;
    w = ref_pick(rv, m_ptr);
    ref_draw(MT_A, m_lfsr, l_after, d, n);
    obs_gnt = int'(ifa.gnt); obs_lat = -1; obs_digit = -1;
    chk("grant", ifa.gnt, 32'(1) << w);
    chk("busy_on", ifa.busy, 1);
    if (abort_at >= 1 && abort_at <= n) begin
      for (int c = 1; c <= abort_at; c++) begin
        @(negedge CLK);
        ifa.seed_load = busy_seed && (c == 1) && (c < abort_at);
        ifa.seed      = 16'($urandom);
        if (c == abort_at) ifa.req = rv & ~(N'(1) << w);
        @(posedge CLK); #1;
        if (c < abort_at) chk("abort_hold_gnt", ifa.gnt, 32'(1) << w);
      end
      chk("abort_gnt", ifa.gnt, 0);
      chk("abort_busy", ifa.busy, 0);
      chk("abort_dv", ifa.digit_valid, 0);
      l_ab = m_lfsr;
      for (int s = 0; s < abort_at; s++) l_ab = ref_step(l_ab);
      m_lfsr = l_ab;
    end else begin
      for (int c = 1; c <= n; c++) begin
        @(negedge CLK);
        ifa.seed_load = busy_seed && (c == 1);
        ifa.seed      = 16'($urandom);
        @(posedge CLK); #1;
        if (ifa.digit_valid && obs_lat < 0) begin
          obs_lat   = c + 1;
          obs_digit = int'(ifa.digit);
        end
        chk("dv_timing", ifa.digit_valid, (c == n));
        chk("hold_gnt", ifa.gnt, 32'(1) << w);
      end
      chk("digit", ifa.digit, d);
      @(negedge CLK);
      ifa.seed_load = 1'b0;
      @(posedge CLK); #1;
      chk("idle_gnt", ifa.gnt, 0);
      chk("idle_busy", ifa.busy, 0);
      chk("idle_dv", ifa.digit_valid, 0);
      chk("digit_hold", ifa.digit, d);
      m_lfsr = l_after;
    end
    m_ptr = (w + 1) % N;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] rr_exp [4];
    logic [N-1:0] rv;
    logic [15:0]  lb;
    int db, nb, got, ab, plan_digit, plan_lat;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100; rr_exp[3] = 4'b1000;
`ifdef RAND_REJECT_EN
    plan_digit = 6; plan_lat = 6;
`else
    plan_digit = 5; plan_lat = 2;
`endif

    RESET = 1'b1;
    ifa.req = '0; ifa.seed_load = 1'b0; ifa.seed = '0;
    ifb.req = '0; ifb.seed_load = 1'b0; ifb.seed = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_gnt", ifa.gnt, 0);
    chk("rst_dv", ifa.digit_valid, 0);
    chk("rst_digit", ifa.digit, 0);
    chk("rst_busy", ifa.busy, 0);
    @(negedge CLK);
    RESET = 1'b0;
    m_lfsr = 16'hBEEF;
    m_ptr  = 0;

    // Short retry budget: forced accept on the third candidate.
    @(negedge CLK);
    ifb.req = 4'b0001;
    @(posedge CLK); #1;
    chk("b_grant", ifb.gnt, 4'b0001);
    ref_draw(MT_B, 16'hBEEF, lb, db, nb);
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge CLK); #1;
      if (ifb.digit_valid) begin got = c; break; end
    end
    chk("b_dv_cycle", got, nb);
    chk("b_digit", ifb.digit, db);
`ifdef RAND_REJECT_EN
    chk("b_digit_plan", ifb.digit, 3);
`else
    chk("b_digit_plan", ifb.digit, 5);
`endif
    @(negedge CLK);
    ifb.req = '0;

    // First transaction from the reset seed.
    do_txn(4'b0001, 0, 1'b0);
    chk("plan_gnt", obs_gnt, 4'b0001);
    chk("plan_digit", obs_digit, plan_digit);
    chk("plan_latency", obs_lat, plan_lat);

    // Round robin with all requests held.
    do_reset();
    for (int t = 0; t < 4; t++) begin
      do_txn(4'b1111, 0, 1'b0);
      chk("rr_order", obs_gnt, rr_exp[t]);
    end
    do_txn(4'b1001, 0, 1'b0);
    chk("rr_wrap", obs_gnt, 4'b0001);

    // Winner drops its request mid-draw.
    do_reset();
`ifdef RAND_REJECT_EN
    do_txn(4'b1111, 2, 1'b0);
`else
    do_txn(4'b1111, 1, 1'b0);
`endif
    do_txn(4'b1111, 0, 1'b0);
    chk("abort_next_gnt", obs_gnt, 4'b0010);

    // Seeding: non-zero seed, zero seed, and seed attempts while busy.
    do_seed(16'h1234);
    do_txn(4'b0100, 0, 1'b0);
    do_seed(16'h0000);
    do_txn(4'b0001, 0, 1'b0);
    chk("seed0_digit", obs_digit, plan_digit);
    do_reset();
    do_txn(4'b0001, 0, 1'b1);
    chk("busy_seed_digit", obs_digit, plan_digit);
    do_txn(4'b0010, 0, 1'b1);
    do_txn(4'b0001, 0, 1'b0);

    // Asynchronous reset in the middle of a transaction.
    @(negedge CLK);
    ifa.req = 4'b0100;
    @(posedge CLK); #1;
    chk("mid_grant", ifa.gnt, 4'b0100);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("mid_rst_gnt", ifa.gnt, 0);
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_dv", ifa.digit_valid, 0);
    chk("mid_rst_digit", ifa.digit, 0);
    @(negedge CLK);
    RESET = 1'b0;
    ifa.req = '0;
    m_lfsr = 16'hBEEF;
    m_ptr  = 0;
    do_txn(4'b1111, 0, 1'b0);
    chk("post_rst_gnt", obs_gnt, 4'b0001);
    chk("post_rst_digit", obs_digit, plan_digit);

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 9) == 0)
        do_seed(($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      rv = N'($urandom_range(1, (1 << N) - 1));
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_txn(rv, ab, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
